// File: rtl/noc.sv
// Shared NoC types, flit header field offsets and the XY dimension-order route function.
package noc;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } xy_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  localparam int messageTypeWidth = 2;

  typedef enum logic [messageTypeWidth-1:0] {
    msgRequest  = 2'd0,
    msgResponse = 2'd1,
    msgWrite    = 2'd2,
    msgControl  = 2'd3
  } message_t;

  typedef enum logic [4:0] {
    goNone  = 5'b00000,
    goLocal = 5'b00001,
    goNorth = 5'b00010,
    goEast  = 5'b00100,
    goSouth = 5'b01000,
    goWest  = 5'b10000
  } direction_t;

  localparam int PortQueueDepth = 4;

  // Field offsets are counted down from the flit MSB so they hold for any DataWidth.
  localparam int PreambleWidth = $bits(preamble_t);
  localparam int XyWidth       = $bits(xy_t);
  localparam int SrcTopOffset  = PreambleWidth;
  localparam int DstTopOffset  = PreambleWidth + XyWidth;
  localparam int MsgTopOffset  = PreambleWidth + 2 * XyWidth;
  localparam int HeaderWidth   = MsgTopOffset + messageTypeWidth;

  function automatic direction_t xy_route(input xy_t pos, input xy_t dest);
    direction_t dir;
    if (dest.x > pos.x)      dir = goEast;
    else if (dest.x < pos.x) dir = goWest;
    else if (dest.y < pos.y) dir = goNorth;
    else if (dest.y > pos.y) dir = goSouth;
    else                     dir = goLocal;
    return dir;
  endfunction

endpackage

// File: rtl/noc_input_fifo.sv
// Flit queue for the NoC input unit: Depth x DataWidth circular buffer, front read from
// registered storage, so a flit written this cycle is visible no earlier than the next.
module noc_input_fifo #(
  parameter int DataWidth = 64,
  parameter int Depth     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [DataWidth-1:0]         i_wr_data,
  input  logic                         i_rd_en,
  output logic [DataWidth-1:0]         o_rd_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(Depth+1)-1:0]   o_count
);

  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW  = $clog2(Depth + 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [AddrW-1:0]     r_wr_ptr;
  logic [AddrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 w_rd;
  logic                 w_wr;

  assign o_full    = (r_count == CntW'(Depth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full queue still accepts a write when the front is dequeued in the same cycle.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] ptr);
    return (ptr == AddrW'(Depth - 1)) ? '0 : ptr + AddrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/noc_input_unit.sv
// NoC router input unit: flit queue, packet FSM with XY routing, error flags and flow control.
// Define NOC_CREDIT_FC_EN for credit-pulse flow control; default is ack/nack stop signalling.
module noc_input_unit
  import noc::*;
#(
  parameter int  DataWidth = 64,
  parameter xy_t Position  = '0,
  parameter int  Depth     = PortQueueDepth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] data_in,
  input  logic                 data_void_in,
  output logic                 flow_out,
  output logic [DataWidth-1:0] data_out,
  output logic                 data_void_out,
  output direction_t           route_out,
  input  logic                 grant_in,
  output logic                 overflow_err,
  output logic                 proto_err
);

  localparam int CntW = $clog2(Depth + 1);

  typedef enum logic {IDLE, PACKET} state_t;

  state_t           r_state;
  direction_t       r_route_q;
  logic             r_flow;
  logic             r_overflow;
  logic             r_proto;

  logic [DataWidth-1:0] w_front;
  logic                 w_full;
  logic                 w_empty;
  logic [CntW-1:0]      w_count;
  logic                 w_head;
  logic                 w_tail;
  xy_t                  w_dest;
  direction_t           w_xy_dir;
  logic                 w_proto_bad;
  logic                 w_void;
  logic                 w_deq;
  logic                 w_wr_req;
  logic                 w_wr_ok;

  noc_input_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_req),
    .i_wr_data (data_in),
    .i_rd_en   (w_deq),
    .o_rd_data (w_front),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_head   = w_front[DataWidth-1];
  assign w_tail   = w_front[DataWidth-2];
  assign w_dest   = w_front[DataWidth-1-DstTopOffset -: XyWidth];
  assign w_xy_dir = xy_route(Position, w_dest);

  // Out-of-sequence flits are hidden from downstream and drained on their own.
  assign w_proto_bad = !w_empty && ((r_state == IDLE) ? !w_head : w_head);
  assign w_void      = w_empty || w_proto_bad;
  assign w_deq       = (!w_void && grant_in) || w_proto_bad;

  assign w_wr_req = !data_void_in && !rst;
  assign w_wr_ok  = w_wr_req && (!w_full || w_deq);

  assign data_out      = w_front;
  assign data_void_out = w_void;
  assign route_out     = w_void ? goNone : ((r_state == IDLE) ? w_xy_dir : r_route_q);
  assign flow_out      = r_flow;
  assign overflow_err  = r_overflow;
  assign proto_err     = r_proto;

`ifdef NOC_CREDIT_FC_EN
  logic w_flow_next;
  logic [CntW-1:0] w_count_unused;
  assign w_count_unused = w_count;
  assign w_flow_next    = w_deq;
`else
  logic [CntW-1:0] w_next_count;
  logic            w_flow_next;
  always_comb begin
    w_next_count = w_count;
    if (w_wr_ok && !w_deq)      w_next_count = w_count + CntW'(1);
    else if (!w_wr_ok && w_deq) w_next_count = w_count - CntW'(1);
  end
  assign w_flow_next = (w_next_count >= CntW'(Depth - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_route_q  <= goNone;
      r_flow     <= 1'b0;
      r_overflow <= 1'b0;
      r_proto    <= 1'b0;
    end else begin
      r_flow <= w_flow_next;
      if (w_wr_req && !w_wr_ok) r_overflow <= 1'b1;
      if (w_proto_bad)          r_proto    <= 1'b1;
      if (w_deq && !w_proto_bad) begin
        case (r_state)
          IDLE: begin
            r_route_q <= w_xy_dir;
            if (!w_tail) r_state <= PACKET;
          end
          PACKET: if (w_tail) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
